// File: rtl/fsic_io_pkg.sv
// ----------------------------------------------------------------------------
// fsic_io_pkg
// Shared constants and types for the FSIC IO transmit path.
//   FSIC_IO_W          - lane width, one bit per TXD output pad
//   FSIC_IO_RATIO      - lane symbols carried by one FSIC frame
//   FSIC_IO_UNDERRUN_W - width of the saturating idle-frame counter
//   fsic_io_state_e    - serializer state (OFF / RUN)
// ----------------------------------------------------------------------------
package fsic_io_pkg;

  localparam int FSIC_IO_W          = 13;
  localparam int FSIC_IO_RATIO      = 4;
  localparam int FSIC_IO_UNDERRUN_W = 16;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } fsic_io_state_e;

endpackage

// File: rtl/fsic_io_tx_serializer_if.sv
// ----------------------------------------------------------------------------
// fsic_io_tx_serializer_if
// Frame handshake between the FSIC core and the TX serializer.
//   tx_data  - one frame, symbol k in tx_data[k*W +: W]
//   tx_valid - frame offered by the core
//   tx_ready - serializer buffer can take a frame
// master: FSIC core side, slave: serializer side.
// ----------------------------------------------------------------------------
interface fsic_io_tx_serializer_if
  import fsic_io_pkg::*;
#(
  parameter int W     = FSIC_IO_W,
  parameter int RATIO = FSIC_IO_RATIO
);

  logic [W*RATIO-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/fsic_io_tx_fifo2.sv
// ----------------------------------------------------------------------------
// fsic_io_tx_fifo2
// Two-entry frame buffer with a first-word-through head output.
//   clk, rst  - clock, asynchronous active-high reset (empties the buffer)
//   push      - write push_data (caller guarantees count < 2)
//   pop       - drop the head entry (caller guarantees count > 0)
//   head_data - oldest stored frame
//   count     - number of stored frames (0..2)
// A push and pop together leave the count unchanged; the pushed frame ends
// up as the new head when only one entry was stored.
// ----------------------------------------------------------------------------
module fsic_io_tx_fifo2
  import fsic_io_pkg::*;
#(
  parameter int DW = FSIC_IO_W * FSIC_IO_RATIO
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count_q;

  // Storage and pointers; each pointer is a single bit toggling between the
  // two slots, so ordering falls out of the pointer walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = count_q;

endmodule

// File: rtl/fsic_io_tx_serializer.sv
// ----------------------------------------------------------------------------
// fsic_io_tx_serializer
// Buffers FSIC transmit frames and sends each one as RATIO lane symbols on
// the TXD pads, each symbol held two IO clocks with a forwarded TXCLK that
// rises mid-symbol. Idle frames are inserted when the buffer runs dry.
//   ioclk        - IO clock, rising edge
//   rst          - asynchronous active-high reset
//   en           - enable, only looked at on frame boundaries
//   tx           - frame handshake (slave side)
//   txd          - lane data to the TXD pads (registered)
//   txclk        - forwarded clock to the TXCLK pad (registered)
//   busy         - serializer is running (registered)
//   underrun_cnt - saturating count of idle frames inserted
// ----------------------------------------------------------------------------
module fsic_io_tx_serializer
  import fsic_io_pkg::*;
#(
  parameter int         W        = FSIC_IO_W,
  parameter int         RATIO    = FSIC_IO_RATIO,
  parameter logic [W-1:0] IDLE_PAT = '0
) (
  input  logic                          ioclk,
  input  logic                          rst,
  input  logic                          en,
  fsic_io_tx_serializer_if.slave        tx,
  output logic [W-1:0]                  txd,
  output logic                          txclk,
  output logic                          busy,
  output logic [FSIC_IO_UNDERRUN_W-1:0] underrun_cnt
);

  localparam int             FW   = W * RATIO;
  localparam int             CW   = $clog2(2 * RATIO);
  localparam logic [CW-1:0]  LAST = CW'(2 * RATIO - 1);

  fsic_io_state_e                state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [FW-1:0]                 sreg_q, sreg_d;
  logic [FSIC_IO_UNDERRUN_W-1:0] und_q, und_d;
  logic [W-1:0]                  txd_q, txd_d;
  logic                          txclk_q, txclk_d;
  logic                          busy_q, busy_d;

  logic                          ready;
  logic                          fifo_push;
  logic                          fifo_pop;
  logic [FW-1:0]                 fifo_head;
  logic [1:0]                    fifo_count;

  // Ready comes from the registered count only, so a pop this cycle cannot
  // open the door until the next one.
  assign ready       = (fifo_count != 2'd2);
  assign tx.tx_ready = ready;
  assign fifo_push   = tx.tx_valid && ready;

  fsic_io_tx_fifo2 #(.DW(FW)) u_fifo (
    .clk       (ioclk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (tx.tx_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  // Next-state logic. A frame load happens either when leaving OFF or at the
  // last half-symbol of a frame with en still high. The empty test uses the
  // registered count, so a frame pushed on the load edge is never bypassed
  // straight into the shift register. Pad outputs are computed from the
  // next state and registered, keeping the pads free of combinational paths.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sreg_d   = sreg_q;
    und_d    = und_q;
    fifo_pop = 1'b0;
    txd_d    = '0;
    txclk_d  = 1'b0;
    busy_d   = 1'b0;

    unique case (state_q)
      OFF: begin
        if (en) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!en) begin
            state_d = OFF;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = OFF;
    endcase

    if (en && ((state_q == OFF) || (cnt_q == LAST))) begin
      if (fifo_count != 2'd0) begin
        fifo_pop = 1'b1;
        sreg_d   = fifo_head;
      end else begin
        sreg_d = {RATIO{IDLE_PAT}};
        if (und_q != '1) begin
          und_d = und_q + 1'b1;
        end
      end
    end

    if (state_d == RUN) begin
      txd_d   = sreg_d[int'(cnt_d[CW-1:1]) * W +: W];
      txclk_d = cnt_d[0];
      busy_d  = 1'b1;
    end
  end

  // State and pad registers; reset returns the pads to quiet immediately.
  always_ff @(posedge ioclk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q   <= '0;
      sreg_q  <= '0;
      und_q   <= '0;
      txd_q   <= '0;
      txclk_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      und_q   <= und_d;
      txd_q   <= txd_d;
      txclk_q <= txclk_d;
      busy_q  <= busy_d;
    end
  end

  assign txd          = txd_q;
  assign txclk        = txclk_q;
  assign busy         = busy_q;
  assign underrun_cnt = und_q;

endmodule

// File: tb/tb_fsic_io_tx_serializer.sv
// ----------------------------------------------------------------------------
// tb_fsic_io_tx_serializer
// Self-checking bench for fsic_io_tx_serializer. A queue-based reference
// model tracks buffered frames, the frame being sent and the idle count;
// each scenario task drives stimulus and compares the pads to the model.
// ----------------------------------------------------------------------------
module tb_fsic_io_tx_serializer;
  import fsic_io_pkg::*;

  localparam int         W     = 13;
  localparam int         RATIO = 4;
  localparam int         FW    = W * RATIO;
  localparam logic [W-1:0] IDLE = 13'h0000;

  logic          ioclk = 1'b0;
  logic          rst   = 1'b0;
  logic          en    = 1'b0;
  bit            clk_en = 1'b0;
  logic [W-1:0]  txd;
  logic          txclk;
  logic          busy;
  logic [15:0]   underrun_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [FW-1:0] model_q[$];
  bit            m_run;
  int            m_pos;
  logic [FW-1:0] m_frame;
  int            m_und;
  logic [W-1:0]  exp_txd;
  logic          exp_txclk;
  logic          exp_busy;
  bit            last_pushed;

  fsic_io_tx_serializer_if #(.W(W), .RATIO(RATIO)) tx_if ();

  fsic_io_tx_serializer #(.W(W), .RATIO(RATIO), .IDLE_PAT(IDLE)) dut (
    .ioclk        (ioclk),
    .rst          (rst),
    .en           (en),
    .tx           (tx_if),
    .txd          (txd),
    .txclk        (txclk),
    .busy         (busy),
    .underrun_cnt (underrun_cnt)
  );

  // Clock is held still until the reset-only test has run.
  always begin
    #5;
    if (clk_en) ioclk = ~ioclk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [FW-1:0] rand_frame();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[FW-1:0];
  endfunction

  task automatic model_reset();
    model_q.delete();
    m_run     = 1'b0;
    m_pos     = 0;
    m_frame   = '0;
    m_und     = 0;
    exp_txd   = '0;
    exp_txclk = 1'b0;
    exp_busy  = 1'b0;
    last_pushed = 1'b0;
  endtask

  // Advance one clock: sample inputs before the edge, then update the model
  // from the frame rules and leave expected pad values for the caller.
  task automatic cycle();
    bit            s_en;
    bit            s_push;
    bit            do_load;
    logic [FW-1:0] s_data;
    s_en   = en;
    s_push = tx_if.tx_valid && (model_q.size() < 2);
    s_data = tx_if.tx_data;
    @(posedge ioclk);
    #1;
    do_load = 1'b0;
    if (!m_run) begin
      if (s_en) begin
        m_run   = 1'b1;
        m_pos   = 0;
        do_load = 1'b1;
      end
    end else if (m_pos == 2 * RATIO - 1) begin
      m_pos = 0;
      if (s_en) do_load = 1'b1;
      else      m_run   = 1'b0;
    end else begin
      m_pos++;
    end
    if (do_load) begin
      if (model_q.size() > 0) begin
        m_frame = model_q.pop_front();
      end else begin
        m_frame = {RATIO{IDLE}};
        if (m_und < 65535) m_und++;
      end
    end
    if (s_push) model_q.push_back(s_data);
    last_pushed = s_push;
    if (m_run) begin
      exp_txd   = m_frame[(m_pos / 2) * W +: W];
      exp_txclk = m_pos[0];
      exp_busy  = 1'b1;
    end else begin
      exp_txd   = '0;
      exp_txclk = 1'b0;
      exp_busy  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge ioclk);
    #1;
    en             = 1'b0;
    tx_if.tx_valid = 1'b0;
    rst            = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  // Offer one frame until accepted; ok reports acceptance within the bound.
  task automatic push_frame(input logic [FW-1:0] frame, output bit ok);
    ok             = 1'b0;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = frame;
    for (int i = 0; i < 8 && !ok; i++) begin
      cycle();
      ok = last_pushed;
    end
    tx_if.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    en             = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks += 5;
    if (txd !== 13'h0) begin errors++; $display("[TB] FAIL reset txd: got %h expected %h", txd, 13'h0); end
    if (txclk !== 1'b0) begin errors++; $display("[TB] FAIL reset txclk: got %b expected 0", txclk); end
    if (tx_if.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset tx_ready: got %b expected 1", tx_if.tx_ready); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    if (underrun_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset underrun_cnt: got %h expected 0", underrun_cnt); end
    #2;
    rst = 1'b0;
    model_reset();
    clk_en = 1'b1;
  endtask

  task automatic test_single_frame();
    bit ok;
    do_reset();
    push_frame({13'h1FFF, 13'h1555, 13'h0AAA, 13'h0001}, ok);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL single push: got not-accepted expected accepted"); end
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (i == 15) en = 1'b0;
      checks += 3;
      if (txd !== exp_txd) begin errors++; $display("[TB] FAIL single txd[%0d]: got %h expected %h", i, txd, exp_txd); end
      if (txclk !== exp_txclk) begin errors++; $display("[TB] FAIL single txclk[%0d]: got %b expected %b", i, txclk, exp_txclk); end
      if (busy !== exp_busy) begin errors++; $display("[TB] FAIL single busy[%0d]: got %b expected %b", i, busy, exp_busy); end
    end
    checks++;
    if (underrun_cnt !== 16'd1) begin errors++; $display("[TB] FAIL single underrun_cnt: got %0d expected 1", underrun_cnt); end
    cycle();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single stop busy: got %b expected 0", busy); end
  endtask

  task automatic test_underrun();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (i == 23) en = 1'b0;
      checks += 3;
      if (txd !== IDLE) begin errors++; $display("[TB] FAIL underrun txd[%0d]: got %h expected %h", i, txd, IDLE); end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL underrun busy[%0d]: got %b expected 1", i, busy); end
      if (underrun_cnt !== 16'(m_und)) begin errors++; $display("[TB] FAIL underrun count[%0d]: got %0d expected %0d", i, underrun_cnt, m_und); end
    end
    checks++;
    if (underrun_cnt !== 16'd3) begin errors++; $display("[TB] FAIL underrun total: got %0d expected 3", underrun_cnt); end
    cycle();
    checks++;
    if (busy !== exp_busy) begin errors++; $display("[TB] FAIL underrun stop busy: got %b expected %b", busy, exp_busy); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [FW-1:0] frame_a, frame_b, frame_c;
    do_reset();
    frame_a = rand_frame();
    frame_b = rand_frame();
    frame_c = rand_frame();
    push_frame(frame_a, ok);
    push_frame(frame_b, ok);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = frame_c;
    #1;
    checks++;
    if (tx_if.tx_ready !== 1'b0) begin errors++; $display("[TB] FAIL backpressure ready full: got %b expected 0", tx_if.tx_ready); end
    en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (last_pushed) tx_if.tx_valid = 1'b0;
      if (i == 23) en = 1'b0;
      checks += 4;
      if (txd !== exp_txd) begin errors++; $display("[TB] FAIL backpressure txd[%0d]: got %h expected %h", i, txd, exp_txd); end
      if (txclk !== exp_txclk) begin errors++; $display("[TB] FAIL backpressure txclk[%0d]: got %b expected %b", i, txclk, exp_txclk); end
      if (tx_if.tx_ready !== (model_q.size() < 2)) begin errors++; $display("[TB] FAIL backpressure ready[%0d]: got %b expected %b", i, tx_if.tx_ready, model_q.size() < 2); end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL backpressure busy[%0d]: got %b expected 1", i, busy); end
    end
    checks++;
    if (underrun_cnt !== 16'd0) begin errors++; $display("[TB] FAIL backpressure underrun_cnt: got %0d expected 0", underrun_cnt); end
    cycle();
  endtask

  task automatic test_graceful_stop();
    bit ok;
    do_reset();
    push_frame(rand_frame(), ok);
    push_frame(rand_frame(), ok);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (i == 3) en = 1'b0;
      checks += 3;
      if (txd !== exp_txd) begin errors++; $display("[TB] FAIL stop txd[%0d]: got %h expected %h", i, txd, exp_txd); end
      if (txclk !== exp_txclk) begin errors++; $display("[TB] FAIL stop txclk[%0d]: got %b expected %b", i, txclk, exp_txclk); end
      if (busy !== exp_busy) begin errors++; $display("[TB] FAIL stop busy[%0d]: got %b expected %b", i, busy, exp_busy); end
    end
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL stop idle busy: got %b expected 0", busy); end
    if (tx_if.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL stop retained ready: got %b expected 1", tx_if.tx_ready); end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 7) en = 1'b0;
      checks += 2;
      if (txd !== exp_txd) begin errors++; $display("[TB] FAIL stop resume txd[%0d]: got %h expected %h", i, txd, exp_txd); end
      if (txclk !== exp_txclk) begin errors++; $display("[TB] FAIL stop resume txclk[%0d]: got %b expected %b", i, txclk, exp_txclk); end
    end
    checks++;
    if (underrun_cnt !== 16'd0) begin errors++; $display("[TB] FAIL stop underrun_cnt: got %0d expected 0", underrun_cnt); end
    cycle();
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    push_frame(rand_frame(), ok);
    push_frame(rand_frame(), ok);
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
    end
    checks++;
    if (txd !== exp_txd) begin errors++; $display("[TB] FAIL areset pre txd: got %h expected %h", txd, exp_txd); end
    #2;
    rst = 1'b1;
    #1;
    checks += 5;
    if (txd !== 13'h0) begin errors++; $display("[TB] FAIL areset txd: got %h expected 0", txd); end
    if (txclk !== 1'b0) begin errors++; $display("[TB] FAIL areset txclk: got %b expected 0", txclk); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL areset busy: got %b expected 0", busy); end
    if (tx_if.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL areset tx_ready: got %b expected 1", tx_if.tx_ready); end
    if (underrun_cnt !== 16'h0) begin errors++; $display("[TB] FAIL areset underrun_cnt: got %0d expected 0", underrun_cnt); end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 7) en = 1'b0;
      checks += 2;
      if (txd !== IDLE) begin errors++; $display("[TB] FAIL areset idle txd[%0d]: got %h expected %h", i, txd, IDLE); end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL areset idle busy[%0d]: got %b expected 1", i, busy); end
    end
    checks++;
    if (underrun_cnt !== 16'd1) begin errors++; $display("[TB] FAIL areset underrun_cnt: got %0d expected 1", underrun_cnt); end
    cycle();
  endtask

  task automatic test_random_stream();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (last_pushed || !tx_if.tx_valid) begin
        tx_if.tx_valid = ($urandom_range(0, 2) != 0);
        tx_if.tx_data  = rand_frame();
      end
      if ($urandom_range(0, 15) == 0) en = ~en;
      cycle();
      checks += 5;
      if (txd !== exp_txd) begin errors++; $display("[TB] FAIL random txd[%0d]: got %h expected %h", i, txd, exp_txd); end
      if (txclk !== exp_txclk) begin errors++; $display("[TB] FAIL random txclk[%0d]: got %b expected %b", i, txclk, exp_txclk); end
      if (busy !== exp_busy) begin errors++; $display("[TB] FAIL random busy[%0d]: got %b expected %b", i, busy, exp_busy); end
      if (tx_if.tx_ready !== (model_q.size() < 2)) begin errors++; $display("[TB] FAIL random ready[%0d]: got %b expected %b", i, tx_if.tx_ready, model_q.size() < 2); end
      if (underrun_cnt !== 16'(m_und)) begin errors++; $display("[TB] FAIL random underrun_cnt[%0d]: got %0d expected %0d", i, underrun_cnt, m_und); end
    end
    tx_if.tx_valid = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_frame();
    test_underrun();
    test_backpressure();
    test_graceful_stop();
    test_async_reset();
    test_random_stream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
